// File: rtl/ft601_tx_ctrl.sv
// FT601 245-synchronous FIFO write sequencer: pulls ADC samples from the async FIFO
// into a 2-entry skid buffer and drives WR_N/FT_DATA bursts under TXE_N back-pressure.
module ft601_tx_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int BUS_WIDTH  = 32,
    parameter int MAX_BURST  = 256,
    parameter int IDLE_GAP   = 1
) (
    input  logic                   FT_CLK,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   fifo_empty,
    output logic                   fifo_r_en,
    input  logic [DATA_WIDTH-1:0]  fifo_data,
    input  logic                   TXE_N,
    output logic                   WR_N,
    output logic [BUS_WIDTH-1:0]   ft_data_out,
    output logic                   ft_data_oe,
    output logic [BUS_WIDTH/8-1:0] BE,
    output logic                   RD_N,
    output logic                   OE_N,
    output logic                   SIWU_N,
    output logic                   busy,
    output logic [31:0]            word_count,
    output logic [1:0]             state_dbg_o
);

    // Handshake: a word moves to the FT601 at every FT_CLK edge where WR_N==0 and TXE_N==0;
    // a FIFO read requested with fifo_r_en at edge t delivers fifo_data for capture at edge t+1.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   wr_n_q, wr_n_d;
    logic [BUS_WIDTH-1:0]   data_out_q, data_out_d;
    logic                   oe_q;
    logic [31:0]            word_count_q, word_count_d;
    logic [15:0]            burst_cnt_q, burst_cnt_d;
    logic [3:0]             gap_cnt_q, gap_cnt_d;
    logic [DATA_WIDTH-1:0]  buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0]  buf1_q, buf1_d;
    logic [1:0]             count_q, count_d;
    logic                   inflight_q, inflight_d;

    logic                   accept;
    logic                   have_data;
    logic                   avail_after_pop;
    logic                   start_ok;
    logic                   burst_more;
    logic                   gap_done;
    logic [2:0]             occ_after;

    assign accept          = ~wr_n_q & ~TXE_N;
    assign have_data       = (count_q != 2'd0) | inflight_q;
    assign avail_after_pop = (count_q == 2'd2) | inflight_q;
    assign start_ok        = enable & ~TXE_N & have_data;
    assign burst_more      = ({1'b0, burst_cnt_q} + 17'd1) < 17'(MAX_BURST);
    assign gap_done        = (gap_cnt_q == 4'(IDLE_GAP - 1));

    // Occupancy after this edge's pop; counting the pop keeps one read per cycle flowing
    // while the buffer can never be asked to hold a third word.
    assign occ_after = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, accept};
    assign fifo_r_en = ~rst & enable & ~fifo_empty & (occ_after < 3'd2);

    always_ff @(posedge FT_CLK or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (TXE_N | ~enable | ~avail_after_pop | ~burst_more) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // The last gap cycle doubles as the IDLE decision cycle so the gap is exact.
                if (gap_done) begin
                    state_d = start_ok ? S_BURST : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_n_d = (state_d != S_BURST);
        busy   = (state_q != S_IDLE) | (count_q != 2'd0);
    end

    always_comb begin
        burst_cnt_d  = (state_q == S_BURST) ? burst_cnt_q + {15'd0, accept} : 16'd0;
        gap_cnt_d    = (state_q == S_GAP && state_d == S_GAP) ? gap_cnt_q + 4'd1 : 4'd0;
        word_count_d = word_count_q + {31'd0, accept};
    end

    always_comb begin
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        count_d    = count_q;
        inflight_d = fifo_r_en;
        case ({accept, inflight_q})
            2'b01: begin
                if (count_q == 2'd0) begin
                    buf0_d  = fifo_data;
                    count_d = 2'd1;
                end else begin
                    buf1_d  = fifo_data;
                    count_d = 2'd2;
                end
            end
            2'b10: begin
                buf0_d  = buf1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Pop and capture together: the arriving word lands behind whatever remains.
                if (count_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_data;
                end else begin
                    buf0_d = fifo_data;
                end
            end
            default: ;
        endcase
        data_out_d                   = '0;
        data_out_d[DATA_WIDTH-1:0]   = buf0_d;
    end

    always_ff @(posedge FT_CLK or posedge rst) begin
        if (rst) begin
            wr_n_q       <= 1'b1;
            data_out_q   <= '0;
            oe_q         <= 1'b0;
            word_count_q <= 32'd0;
            burst_cnt_q  <= 16'd0;
            gap_cnt_q    <= 4'd0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            count_q      <= 2'd0;
            inflight_q   <= 1'b0;
        end else begin
            wr_n_q       <= wr_n_d;
            data_out_q   <= data_out_d;
            oe_q         <= 1'b1;
            word_count_q <= word_count_d;
            burst_cnt_q  <= burst_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
        end
    end

    assign WR_N        = wr_n_q;
    assign ft_data_out = data_out_q;
    assign ft_data_oe  = oe_q;
    assign BE          = '1;
    assign RD_N        = 1'b1;
    assign OE_N        = 1'b1;
    assign SIWU_N      = 1'b1;
    assign word_count  = word_count_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_ft601_tx_ctrl.sv
// Bench for ft601_tx_ctrl: FIFO and FT601 models, in-order delivery scoreboard, burst/gap rules.
module tb_ft601_tx_ctrl;

    localparam int DW  = 16;
    localparam int BW  = 32;
    localparam int MB  = 4;
    localparam int GAP = 2;

    logic           FT_CLK = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic           fifo_empty = 1'b1;
    logic           TXE_N = 1'b1;
    logic [DW-1:0]  fifo_data = '0;
    logic           fifo_r_en, WR_N, ft_data_oe, RD_N, OE_N, SIWU_N, busy;
    logic [BW-1:0]  ft_data_out;
    logic [BW/8-1:0] BE;
    logic [31:0]    word_count;
    logic [1:0]     state_dbg;

    logic [DW-1:0]  fifo_q[$];
    logic [BW-1:0]  exp_q[$];
    logic [BW-1:0]  acc_log[$];
    int             checks = 0;
    int             failures = 0;
    int             wc_model = 0;
    int             reads_total = 0;
    int             low_run = 0;
    int             high_run = 0;
    bit             seen_burst = 1'b0;
    bit             rd_pending = 1'b0;

    ft601_tx_ctrl #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .MAX_BURST(MB), .IDLE_GAP(GAP)) dut (
        .FT_CLK(FT_CLK), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_r_en(fifo_r_en), .fifo_data(fifo_data), .TXE_N(TXE_N), .WR_N(WR_N),
        .ft_data_out(ft_data_out), .ft_data_oe(ft_data_oe), .BE(BE), .RD_N(RD_N),
        .OE_N(OE_N), .SIWU_N(SIWU_N), .busy(busy), .word_count(word_count),
        .state_dbg_o(state_dbg)
    );

    always #5 FT_CLK = ~FT_CLK;

    task automatic model_clear();
        exp_q.delete();
        acc_log.delete();
        wc_model    = 0;
        reads_total = 0;
        low_run     = 0;
        high_run    = 0;
        seen_burst  = 1'b0;
        rd_pending  = 1'b0;
    endtask

    // One FT_CLK cycle, entered and left 1 time unit after a rising edge.
    task automatic cycle();
        logic [BW-1:0] e;
        fifo_empty = (fifo_q.size() == 0);
        @(negedge FT_CLK);
        if (fifo_empty || !enable) begin
            checks++;
            if (fifo_r_en !== 1'b0) begin
                failures++;
                $display("FAIL rd_gate: fifo_r_en=%b (empty=%b enable=%b) expected 0", fifo_r_en, fifo_empty, enable);
            end
        end
        if (WR_N === 1'b0 && TXE_N === 1'b0) begin
            checks++;
            acc_log.push_back(ft_data_out);
            wc_model++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL stale_accept: accepted %h with no word outstanding", ft_data_out);
            end else begin
                e = exp_q.pop_front();
                if (ft_data_out !== e) begin
                    failures++;
                    $display("FAIL accept_data: got %h expected %h", ft_data_out, e);
                end
            end
        end
        if (WR_N === 1'b0) begin
            if (low_run == 0 && seen_burst) begin
                checks++;
                if (high_run < GAP) begin
                    failures++;
                    $display("FAIL gap_min: gap of %0d cycles, expected >= %0d", high_run, GAP);
                end
            end
            low_run++;
            high_run   = 0;
            seen_burst = 1'b1;
        end else begin
            if (low_run > 0) begin
                checks++;
                if (low_run > MB) begin
                    failures++;
                    $display("FAIL burst_max: burst of %0d words, expected <= %0d", low_run, MB);
                end
            end
            low_run = 0;
            high_run++;
        end
        rd_pending = (fifo_r_en === 1'b1);
        @(posedge FT_CLK);
        #1;
        if (rd_pending && fifo_q.size() != 0) begin
            fifo_data = fifo_q.pop_front();
            exp_q.push_back(BW'(fifo_data));
            reads_total++;
        end
        rd_pending = 1'b0;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        TXE_N  = 1'b1;
        repeat (2) @(posedge FT_CLK);
        #1;
        model_clear();
        fifo_empty = (fifo_q.size() == 0);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        enable = 1'b1;
        TXE_N  = 1'b0;
        n = 0;
        while (!(fifo_q.size() == 0 && exp_q.size() == 0 && WR_N === 1'b1 && busy === 1'b0) && n < 300) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL drain_timeout: fifo=%0d pending=%0d WR_N=%b busy=%b", fifo_q.size(), exp_q.size(), WR_N, busy);
        end
        checks++;
        if (word_count !== wc_model) begin
            failures++;
            $display("FAIL word_count: got %0d expected %0d", word_count, wc_model);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        TXE_N = 1'b0;
        fifo_q.push_back(16'h1234);
        fifo_empty = 1'b0;
        @(posedge FT_CLK);
        #1;
        checks++; if (WR_N !== 1'b1) begin failures++; $display("FAIL rst_wr_n: got %b expected 1", WR_N); end
        checks++; if (ft_data_out !== '0) begin failures++; $display("FAIL rst_data: got %h expected 0", ft_data_out); end
        checks++; if (ft_data_oe !== 1'b0) begin failures++; $display("FAIL rst_oe: got %b expected 0", ft_data_oe); end
        checks++; if (BE !== 4'hF) begin failures++; $display("FAIL rst_be: got %h expected f", BE); end
        checks++; if ({RD_N, OE_N, SIWU_N} !== 3'b111) begin failures++; $display("FAIL rst_rd_strobes: got %b expected 111", {RD_N, OE_N, SIWU_N}); end
        checks++; if (word_count !== 32'd0) begin failures++; $display("FAIL rst_wc: got %0d expected 0", word_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (fifo_r_en !== 1'b0) begin failures++; $display("FAIL rst_ren: got %b expected 0", fifo_r_en); end
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d expected 0", state_dbg); end
        rst = 1'b0;
        #1;
        checks++; if (ft_data_oe !== 1'b0) begin failures++; $display("FAIL oe_before_edge: got %b expected 0", ft_data_oe); end
        @(posedge FT_CLK);
        #1;
        checks++; if (ft_data_oe !== 1'b1) begin failures++; $display("FAIL oe_after_edge: got %b expected 1", ft_data_oe); end
        fifo_q.delete();
        do_reset();
    endtask

    task automatic test_preload();
        logic exp_wr;
        fifo_q.delete();
        do_reset();
        TXE_N = 1'b0;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
        fifo_empty = 1'b0;
        enable = 1'b1;
        #1;
        checks++;
        if (fifo_r_en !== 1'b1) begin failures++; $display("FAIL preload_ren_c0: got %b expected 1", fifo_r_en); end
        for (int c = 0; c < 16; c++) begin
            exp_wr = !((c >= 2 && c <= 5) || (c >= 8 && c <= 11));
            checks++;
            if (WR_N !== exp_wr) begin
                failures++;
                $display("FAIL preload_wr_n: cycle %0d got %b expected %b", c, WR_N, exp_wr);
            end
            cycle();
        end
        checks++; if (word_count !== 32'd8) begin failures++; $display("FAIL preload_wc: got %0d expected 8", word_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL preload_busy: got %b expected 0", busy); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL preload_undelivered: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_continuous();
        int pushed, n, run, bursts, gap_seen;
        logic prev_wr;
        logic [DW-1:0] nxt;
        fifo_q.delete();
        do_reset();
        TXE_N = 1'b0;
        enable = 1'b1;
        pushed = 0; n = 0; run = 0; bursts = 0; gap_seen = 0;
        prev_wr = 1'b1;
        nxt = 16'h0100;
        while (!(pushed == 24 && fifo_q.size() == 0 && exp_q.size() == 0 && WR_N === 1'b1 && busy === 1'b0) && n < 200) begin
            while (pushed < 24 && fifo_q.size() < 4) begin
                fifo_q.push_back(nxt);
                nxt++;
                pushed++;
            end
            if (WR_N !== prev_wr) begin
                if (prev_wr == 1'b0) begin
                    bursts++;
                    checks++;
                    if (run != MB) begin failures++; $display("FAIL cont_burst_len: burst %0d got %0d expected %0d", bursts, run, MB); end
                end else if (bursts > 0) begin
                    gap_seen++;
                    checks++;
                    if (run != GAP) begin failures++; $display("FAIL cont_gap_len: gap %0d got %0d expected %0d", gap_seen, run, GAP); end
                end
                run = 0;
                prev_wr = WR_N;
            end
            run++;
            cycle();
            n++;
        end
        checks++; if (n >= 200) begin failures++; $display("FAIL cont_timeout: pushed %0d pending %0d", pushed, exp_q.size()); end
        checks++; if (bursts != 6) begin failures++; $display("FAIL cont_bursts: got %0d expected 6", bursts); end
        checks++; if (word_count !== 32'd24) begin failures++; $display("FAIL cont_wc: got %0d expected 24", word_count); end
    endtask

    task automatic test_txe_pulse();
        int n, idx;
        fifo_q.delete();
        do_reset();
        TXE_N = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 10; i++) fifo_q.push_back(DW'(i));
        n = 0;
        while (!(WR_N === 1'b0 && ft_data_out === 32'd5) && n < 40) begin
            cycle();
            n++;
        end
        checks++; if (n >= 40) begin failures++; $display("FAIL txe_reach_head5: head %h WR_N %b", ft_data_out, WR_N); end
        idx = acc_log.size();
        TXE_N = 1'b1;
        cycle();
        checks++; if (WR_N !== 1'b1) begin failures++; $display("FAIL txe_wr_n_next: got %b expected 1", WR_N); end
        checks++; if (ft_data_out !== 32'd5) begin failures++; $display("FAIL txe_head_kept: got %h expected 5", ft_data_out); end
        cycle();
        cycle();
        checks++; if (WR_N !== 1'b1) begin failures++; $display("FAIL txe_wr_n_held: got %b expected 1", WR_N); end
        drain();
        checks++;
        if (acc_log.size() < idx + 2) begin
            failures++; $display("FAIL txe_resume_count: got %0d expected >= %0d", acc_log.size(), idx + 2);
        end else begin
            if (acc_log[idx] !== 32'd5 || acc_log[idx+1] !== 32'd6) begin
                failures++; $display("FAIL txe_resume_order: got %h,%h expected 5,6", acc_log[idx], acc_log[idx+1]);
            end
        end
    endtask

    task automatic test_enable_drop();
        int n;
        fifo_q.delete();
        do_reset();
        TXE_N = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 6; i++) fifo_q.push_back(DW'(i));
        n = 0;
        while (!(WR_N === 1'b0 && ft_data_out === 32'd2) && n < 40) begin
            cycle();
            n++;
        end
        checks++; if (n >= 40) begin failures++; $display("FAIL en_reach_word2: head %h WR_N %b", ft_data_out, WR_N); end
        enable = 1'b0;
        cycle();
        checks++; if (WR_N !== 1'b1) begin failures++; $display("FAIL en_wr_n_next: got %b expected 1", WR_N); end
        checks++; if (fifo_r_en !== 1'b0) begin failures++; $display("FAIL en_ren: got %b expected 0", fifo_r_en); end
        checks++; if (word_count !== 32'd2) begin failures++; $display("FAIL en_wc2: got %0d expected 2", word_count); end
        repeat (5) cycle();
        checks++; if (WR_N !== 1'b1) begin failures++; $display("FAIL en_wr_n_idle: got %b expected 1", WR_N); end
        checks++; if (word_count !== 32'd2) begin failures++; $display("FAIL en_wc_hold: got %0d expected 2", word_count); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL en_busy_held: got %b expected 1", busy); end
        drain();
        checks++; if (word_count !== 32'd6) begin failures++; $display("FAIL en_wc6: got %0d expected 6", word_count); end
    endtask

    task automatic test_reset_mid_burst();
        int n, remaining;
        logic [BW-1:0] first_exp;
        fifo_q.delete();
        do_reset();
        TXE_N = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 10; i++) fifo_q.push_back(DW'(i));
        n = 0;
        while (!(WR_N === 1'b0 && ft_data_out === 32'd3) && n < 40) begin
            cycle();
            n++;
        end
        checks++; if (n >= 40) begin failures++; $display("FAIL rmb_reach_word3: head %h WR_N %b", ft_data_out, WR_N); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (WR_N !== 1'b1) begin failures++; $display("FAIL rmb_wr_n: got %b expected 1", WR_N); end
        checks++; if (word_count !== 32'd0) begin failures++; $display("FAIL rmb_wc: got %0d expected 0", word_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmb_busy: got %b expected 0", busy); end
        checks++; if (fifo_r_en !== 1'b0) begin failures++; $display("FAIL rmb_ren: got %b expected 0", fifo_r_en); end
        @(posedge FT_CLK);
        #1;
        model_clear();
        remaining = fifo_q.size();
        first_exp = (remaining > 0) ? BW'(fifo_q[0]) : '0;
        rst = 1'b0;
        drain();
        checks++;
        if (acc_log.size() == 0) begin
            failures++; $display("FAIL rmb_first_word: got none expected %h", first_exp);
        end else if (acc_log[0] !== first_exp) begin
            failures++; $display("FAIL rmb_first_word: got %h expected %h", acc_log[0], first_exp);
        end
        checks++; if (word_count !== 32'(remaining)) begin failures++; $display("FAIL rmb_wc_after: got %0d expected %0d", word_count, remaining); end
    endtask

    task automatic test_dry();
        int pushed;
        fifo_q.delete();
        do_reset();
        TXE_N = 1'b0;
        enable = 1'b1;
        pushed = 0;
        for (int n = 0; n < 80; n++) begin
            if ((n % 2) == 0 && pushed < 16) begin
                fifo_q.push_back(DW'($urandom_range(0, 65535)));
                pushed++;
            end
            cycle();
        end
        drain();
        checks++; if (word_count !== 32'(reads_total)) begin failures++; $display("FAIL dry_wc_reads: got %0d expected %0d", word_count, reads_total); end
        checks++; if (reads_total != 16) begin failures++; $display("FAIL dry_reads: got %0d expected 16", reads_total); end
    endtask

    task automatic test_random();
        fifo_q.delete();
        do_reset();
        for (int n = 0; n < 300; n++) begin
            enable = ($urandom_range(0, 9) != 0);
            TXE_N  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) fifo_q.push_back(DW'($urandom_range(0, 65535)));
            cycle();
        end
        drain();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_undelivered: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_continuous();
        test_txe_pulse();
        test_enable_drop();
        test_reset_mid_burst();
        test_dry();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
